order_3_drain: RTL and testbench
================================

Name: order_3_drain

Overview:
- Consumer end of the 3-element sort path; the "reader" for triplets produced by the 3-input sorter.
- Accepts one sorted triplet per handshake on the input side, buffering up to 2 triplets.
- Serializes each triplet onto a single-element valid/ready stream, largest first, tagged with rank and last.
- Checks the descending-order guarantee of every accepted triplet and raises a sticky error on violation.

Parameters:
DSIZE, 8, data element width in bits (unsigned compare).

Ports:
clock  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  triplet present on indata0..2
in_ready  output  1  block can accept a triplet this cycle
indata0  input  DSIZE  largest element (rank 0)
indata1  input  DSIZE  middle element (rank 1)
indata2  input  DSIZE  smallest element (rank 2)
out_valid  output  1  outdata/out_rank/out_last valid
out_ready  input  1  downstream accepts element
outdata  output  DSIZE  current serialized element
out_rank  output  2  rank of outdata within its triplet (0,1,2)
out_last  output  1  high when out_rank==2
order_err  output  1  sticky: an accepted triplet was not descending
err_clr  input  1  synchronous clear of order_err

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, write/read pointers 0, rank counter 0, order_err 0. Outputs: out_valid 0, outdata 0, out_rank 0, out_last 0, in_ready 1.
- Buffer: 2-entry triplet FIFO (3*DSIZE per entry), 1-bit write and read pointers, 2-bit occupancy count (0..2).
  - Input accept: in_valid && in_ready.
  - in_ready = (count != 2), combinational from registered count only. No same-cycle pass-through when full, even if the last element of the head triplet is popping that cycle.
- Output:
  - out_valid = (count != 0).
  - outdata = head entry element selected by rank counter.
  - out_rank = rank counter; out_last = (rank counter == 2).
  - All outputs are driven from registers and muxes only; no combinational path from in_* or out_ready to out_*.
- Element pop: out_valid && out_ready.
  - On pop with rank < 2: rank increments.
  - On pop with rank == 2: rank returns to 0, the read pointer toggles, and the head entry is freed.
- Latency: a triplet accepted at edge N is visible (out_valid=1, rank 0) after edge N if the FIFO was empty.
  - Sustained throughput: 1 element/cycle, i.e. 1 triplet per 3 cycles when out_ready is held high.
- Simultaneous accept and final pop (rank 2) in the same cycle: count unchanged, both pointers advance. Legal only when count was 1 before the edge, since in_ready=0 at count 2.
- out_ready low: outdata, out_rank and out_last hold stable while out_valid is high.
- Order check at accept: order_err sets if !(indata0 >= indata1) or !(indata1 >= indata2), unsigned.
  - Equal values are legal.
  - The triplet is still stored and emitted unchanged.
  - err_clr=1 clears order_err at the next edge; if a violating accept occurs in the same cycle, set wins.
- in_valid while in_ready=0: ignored; the upstream holds the data.
- Reset mid-stream: any partially drained triplet is discarded; no output resumes after reset release.

Test Plan:
- Single triplet {0x90,0x40,0x05}, out_ready=1 → 3 consecutive beats: outdata 0x90/0x40/0x05, rank 0/1/2, out_last only on beat 3. out_valid rises one edge after accept. order_err stays 0.
- Back-to-back triplets {0xFF,0x80,0x00} then {0x33,0x33,0x33}, in_valid held high, out_ready=0 → both accepted, then in_ready=0. Releasing out_ready drains 6 beats in order. in_ready returns to 1 in the cycle after the third pop.
- Full buffer, then pop rank 2 of head while in_valid=1 → third triplet not accepted that cycle. It is accepted on the following cycle; no element lost or duplicated.
- Backpressure: toggle out_ready 1,0,0,1 during a triplet → outdata/out_rank stable while stalled; total of 3 beats.
- Bad order {0x10,0x20,0x05} → order_err=1 after accept; beats emitted 0x10,0x20,0x05 unchanged. err_clr pulse → order_err=0. err_clr coincident with another bad triplet → order_err stays 1.
- rst_n asserted low asynchronously mid-triplet after rank 1 → out_valid=0 and in_ready=1 immediately, outdata 0. Next accepted triplet starts at rank 0.

Source files
------------

// File: rtl/order_3_drain.sv
// ---------------------------------------------------------------------------
// order_3_drain
//
// Consumer end of the 3-element sort path. Accepts one sorted triplet per
// input handshake into a 2-entry triplet FIFO, then serializes each triplet
// onto a single-element valid/ready stream, largest element first. Each
// element is tagged with its rank (0,1,2) and a last flag. Every accepted
// triplet is checked for descending order, and order_err latches a
// violation until err_clr.
//
// Ports:
//   clock      in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   triplet present on indata0..2
//   in_ready   out  block can accept a triplet this cycle
//   indata0    in   largest element  (rank 0)
//   indata1    in   middle element   (rank 1)
//   indata2    in   smallest element (rank 2)
//   out_valid  out  outdata/out_rank/out_last valid
//   out_ready  in   downstream accepts the current element
//   outdata    out  current serialized element
//   out_rank   out  rank of outdata within its triplet
//   out_last   out  high on the rank-2 element
//   order_err  out  sticky flag: an accepted triplet was not descending
//   err_clr    in   synchronous clear of order_err
// ---------------------------------------------------------------------------
module order_3_drain #(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] indata0,
  input  logic [DSIZE-1:0] indata1,
  input  logic [DSIZE-1:0] indata2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] outdata,
  output logic [1:0]       out_rank,
  output logic             out_last,
  output logic             order_err,
  input  logic             err_clr
);

  // Each entry holds one triplet; element [k] is the rank-k value.
  logic [2:0][DSIZE-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic [1:0]            r_rank;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_free;
  logic                  w_bad;
  logic [2:0][DSIZE-1:0] w_head;

  // in_ready depends only on the registered count, so a full buffer never
  // admits a triplet even while its head is being freed this cycle.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_rank  = r_rank;
  assign out_last  = (r_rank == 2'd2);
  assign order_err = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_free   = w_pop && (r_rank == 2'd2);
  assign w_bad    = (indata0 < indata1) || (indata1 < indata2);

  // Output element mux: head entry indexed by the rank counter.
  always_comb begin
    w_head  = r_mem[r_rptr];
    outdata = w_head[0];
    case (r_rank)
      2'd1:    outdata = w_head[1];
      2'd2:    outdata = w_head[2];
      default: outdata = w_head[0];
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_rank   <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wptr] <= {indata2, indata1, indata0};
        r_wptr        <= ~r_wptr;
      end

      // Rank walks 0,1,2 per popped element; the final pop frees the head.
      if (w_pop) begin
        if (r_rank == 2'd2) begin
          r_rank <= 2'd0;
          r_rptr <= ~r_rptr;
        end else begin
          r_rank <= r_rank + 2'd1;
        end
      end

      // Accept and head-free in one cycle leave the occupancy unchanged.
      case ({w_accept, w_free})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // A violating accept takes priority over a coincident clear.
      if (w_accept && w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_order_3_drain.sv
// ---------------------------------------------------------------------------
// tb_order_3_drain
//
// Self-checking bench for order_3_drain. A reference model holds the
// buffered triplets as a queue plus the index of the next element to emit;
// directed scenarios check fixed values and a randomized run checks every
// output against the model each cycle.
// ---------------------------------------------------------------------------
module tb_order_3_drain;

  localparam int DSIZE = 8;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] indata0;
  logic [DSIZE-1:0] indata1;
  logic [DSIZE-1:0] indata2;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] outdata;
  logic [1:0]       out_rank;
  logic             out_last;
  logic             order_err;
  logic             err_clr;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } trip_t;

  // Reference model: triplets held by the block, next element index, error.
  trip_t mq[$];
  int    mRank = 0;
  bit    mErr  = 1'b0;

  order_3_drain #(.DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .indata0   (indata0),
    .indata1   (indata1),
    .indata2   (indata2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outdata   (outdata),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .order_err (order_err),
    .err_clr   (err_clr)
  );

  always #5 clock = ~clock;

  // Hard stop in case something stalls the sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] elemOf(trip_t t, int idx);
    if (idx == 0) return t.e0;
    if (idx == 1) return t.e1;
    return t.e2;
  endfunction

  // Drives one cycle of inputs at the falling edge, advances the model at
  // the rising edge, and returns at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input bit ordy, input bit ec);
    bit acc;
    bit pop;
    trip_t t;
    in_valid  = v;
    indata0   = a;
    indata1   = b;
    indata2   = c;
    out_ready = ordy;
    err_clr   = ec;
    acc = v && (mq.size() < 2);
    pop = (mq.size() > 0) && ordy;
    @(posedge clock);
    if (pop) begin
      mRank++;
      if (mRank == 3) begin
        void'(mq.pop_front());
        mRank = 0;
      end
    end
    if (acc) begin
      t.e0 = a;
      t.e1 = b;
      t.e2 = c;
      mq.push_back(t);
    end
    if (acc && ((a < b) || (b < c))) mErr = 1'b1;
    else if (ec) mErr = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    testsRun++;
    if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    testsRun++;
    if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    testsRun++;
    if (outdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_outdata: got %h want 00", outdata); end
    testsRun++;
    if (out_rank !== 2'd0 || out_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rank_last: got rank %0d last %b want 0 0", out_rank, out_last); end
    testsRun++;
    if (order_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_order_err: got %b want 0", order_err); end
  endtask

  task automatic test_single();
    logic [7:0] exp [3];
    exp[0] = 8'h90; exp[1] = 8'h40; exp[2] = 8'h05;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_pre: got valid %b ready %b want 0 1", out_valid, in_ready); end
    applyStimulus(1'b1, 8'h90, 8'h40, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_valid%0d: got %b want 1", i, out_valid); end
      testsRun++;
      if (outdata !== exp[i]) begin testsFailed++; $display("[TB] FAIL single_data%0d: got %h want %h", i, outdata, exp[i]); end
      testsRun++;
      if (out_rank !== 2'(i) || out_last !== (i == 2)) begin testsFailed++; $display("[TB] FAIL single_rank%0d: got rank %0d last %b want %0d %b", i, out_rank, out_last, i, (i == 2)); end
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    testsRun++;
    if (out_valid !== 1'b0 || order_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_post: got valid %b err %b want 0 0", out_valid, order_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    exp[0] = 8'hFF; exp[1] = 8'h80; exp[2] = 8'h00;
    exp[3] = 8'h33; exp[4] = 8'h33; exp[5] = 8'h33;
    applyStimulus(1'b1, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0);
    testsRun++;
    if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_ready_one: got %b want 1", in_ready); end
    applyStimulus(1'b1, 8'h33, 8'h33, 8'h33, 1'b0, 1'b0);
    testsRun++;
    if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_ready_full: got %b want 0", in_ready); end
    for (int i = 0; i < 6; i++) begin
      testsRun++;
      if (out_valid !== 1'b1 || outdata !== exp[i] || out_rank !== 2'(i % 3)) begin
        testsFailed++;
        $display("[TB] FAIL b2b_beat%0d: got valid %b data %h rank %0d want 1 %h %0d", i, out_valid, outdata, out_rank, exp[i], i % 3);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      if (i == 2) begin
        testsRun++;
        if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_ready_return: got %b want 1", in_ready); end
      end
    end
    testsRun++;
    if (out_valid !== 1'b0 || order_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_post: got valid %b err %b want 0 0", out_valid, order_err); end
  endtask

  task automatic test_full_pop();
    logic [7:0] t1 [3];
    logic [7:0] exp [5];
    int beats;
    t1[0] = 8'hC0; t1[1] = 8'hB0; t1[2] = 8'hA0;
    exp[0] = 8'h80; exp[1] = 8'h70; exp[2] = 8'h60; exp[3] = 8'h50; exp[4] = 8'h40;
    applyStimulus(1'b1, 8'hC0, 8'hB0, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h90, 8'h80, 8'h70, 1'b0, 1'b0);
    // Third triplet offered continuously while the head drains.
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ready%0d: got %b want 0", i, in_ready); end
      testsRun++;
      if (outdata !== t1[i]) begin testsFailed++; $display("[TB] FAIL full_head%0d: got %h want %h", i, outdata, t1[i]); end
      applyStimulus(1'b1, 8'h60, 8'h50, 8'h40, 1'b1, 1'b0);
    end
    testsRun++;
    if (in_ready !== 1'b1 || out_rank !== 2'd0 || outdata !== 8'h90) begin
      testsFailed++;
      $display("[TB] FAIL full_after_free: got ready %b rank %0d data %h want 1 0 90", in_ready, out_rank, outdata);
    end
    applyStimulus(1'b1, 8'h60, 8'h50, 8'h40, 1'b1, 1'b0);
    beats = 0;
    for (int c = 0; c < 20 && out_valid === 1'b1; c++) begin
      if (beats < 5) begin
        testsRun++;
        if (outdata !== exp[beats]) begin testsFailed++; $display("[TB] FAIL full_drain%0d: got %h want %h", beats, outdata, exp[beats]); end
      end
      beats++;
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    testsRun++;
    if (beats != 5) begin testsFailed++; $display("[TB] FAIL full_beat_count: got %0d want 5", beats); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3];
    bit pat [7];
    int beats;
    exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'h11;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1; pat[6] = 1;
    applyStimulus(1'b1, 8'hA5, 8'h5A, 8'h11, 1'b0, 1'b0);
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      if (out_valid === 1'b1 && beats < 3) begin
        testsRun++;
        if (outdata !== exp[beats] || out_rank !== 2'(beats)) begin
          testsFailed++;
          $display("[TB] FAIL bp_cycle%0d: got data %h rank %0d want %h %0d", i, outdata, out_rank, exp[beats], beats);
        end
        if (pat[i]) beats++;
      end else if (out_valid === 1'b1) begin
        beats++;
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, pat[i], 1'b0);
    end
    testsRun++;
    if (beats != 3 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_total: got beats %0d valid %b want 3 0", beats, out_valid); end
  endtask

  task automatic test_order_err();
    logic [7:0] exp [3];
    exp[0] = 8'h10; exp[1] = 8'h20; exp[2] = 8'h05;
    applyStimulus(1'b1, 8'h10, 8'h20, 8'h05, 1'b1, 1'b0);
    testsRun++;
    if (order_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_set: got %b want 1", order_err); end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (outdata !== exp[i]) begin testsFailed++; $display("[TB] FAIL err_beat%0d: got %h want %h", i, outdata, exp[i]); end
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    testsRun++;
    if (order_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky: got %b want 1", order_err); end
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    testsRun++;
    if (order_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_clear: got %b want 0", order_err); end
    applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    testsRun++;
    if (order_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_set_wins: got %b want 1", order_err); end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    testsRun++;
    if (order_err !== 1'b0 || out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_final: got err %b valid %b want 0 0", order_err, out_valid); end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 8'h77, 8'h66, 8'h55, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    testsRun++;
    if (out_rank !== 2'd1 || outdata !== 8'h66) begin testsFailed++; $display("[TB] FAIL arst_pre: got rank %0d data %h want 1 66", out_rank, outdata); end
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete();
    mRank = 0;
    mErr  = 1'b0;
    #1;
    testsRun++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || outdata !== 8'h00 || out_rank !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL arst_immediate: got valid %b ready %b data %h rank %0d want 0 1 00 0", out_valid, in_ready, outdata, out_rank);
    end
    @(negedge clock);
    rst_n = 1'b1;
    idle();
    testsRun++;
    if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL arst_no_resume: got %b want 0", out_valid); end
    applyStimulus(1'b1, 8'h44, 8'h22, 8'h11, 1'b0, 1'b0);
    testsRun++;
    if (out_valid !== 1'b1 || out_rank !== 2'd0 || outdata !== 8'h44) begin
      testsFailed++;
      $display("[TB] FAIL arst_next: got valid %b rank %0d data %h want 1 0 44", out_valid, out_rank, outdata);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] a, b, c, s;
    bit v, ordy, ec;
    for (int n = 0; n < 600; n++) begin
      testsRun++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
        testsFailed++;
        $display("[TB] FAIL rand_flow%0d: got valid %b ready %b want %b %b", n, out_valid, in_ready, (mq.size() != 0), (mq.size() < 2));
      end
      if (mq.size() != 0) begin
        testsRun++;
        if (outdata !== elemOf(mq[0], mRank) || out_rank !== 2'(mRank) || out_last !== (mRank == 2)) begin
          testsFailed++;
          $display("[TB] FAIL rand_elem%0d: got data %h rank %0d last %b want %h %0d %b", n, outdata, out_rank, out_last, elemOf(mq[0], mRank), mRank, (mRank == 2));
        end
      end
      testsRun++;
      if (order_err !== mErr) begin testsFailed++; $display("[TB] FAIL rand_err%0d: got %b want %b", n, order_err, mErr); end
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      if (($urandom % 8) == 7) begin b = a; c = a; end
      if (($urandom % 5) != 0) begin
        if (a < b) begin s = a; a = b; b = s; end
        if (b < c) begin s = b; b = c; c = s; end
        if (a < b) begin s = a; a = b; b = s; end
      end
      v    = ($urandom % 3) != 0;
      ordy = ($urandom % 4) != 0;
      ec   = ($urandom % 10) == 0;
      applyStimulus(v, a, b, c, ordy, ec);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    indata0   = '0;
    indata1   = '0;
    indata2   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    @(negedge clock);
    test_reset();
    rst_n = 1'b1;
    idle();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_backpressure();
    test_order_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
